// File: rtl/uart_rx_framed.sv
// Framed UART receiver: 2-flop synchronised line, mid-bit sampling, optional parity,
// one or two stop bits, and a single-entry output register with valid/ready handshake.
module uart_rx_framed #(
    parameter int CLK_SPEED = 5_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 framing_err,
    output logic                 overrun_err,
    output logic                 busy
);
    localparam int BAUD_TICK      = CLK_SPEED / BAUD_RATE;
    localparam int HALF_BAUD_TICK = BAUD_TICK / 2;
    localparam int CNT_W          = $clog2(BAUD_TICK);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(BAUD_TICK - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BAUD_TICK - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    logic [1:0]           settle_q;
    logic                 load_s, frame_ferr_s;
    logic [DATA_BITS-1:0] data_out_q;
    logic                 data_valid_q, parity_err_q, framing_err_q, overrun_err_q;

    function automatic logic parity_error(input logic [DATA_BITS-1:0] d, input logic p);
        if (PARITY == 1) begin
            return ~(^d ^ p);
        end else if (PARITY == 2) begin
            return ^d ^ p;
        end else begin
            return 1'b0;
        end
    endfunction

    // Synchroniser; rx_prev_q only counts as a real "previous high" once the forced
    // reset ones have flushed, so a line low at reset release cannot fake a start edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            settle_q  <= 2'b00;
            rx_prev_q <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            settle_q  <= {settle_q[0], 1'b1};
            rx_prev_q <= settle_q[1] & rx_sync_q;
        end
    end

    // Frame decoder state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 4'd0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state logic: half-bit start qualification, then one sample per bit period.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        stop_d       = stop_q;
        shift_d      = shift_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        load_s       = 1'b0;
        frame_ferr_s = ferr_q;
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                bit_d  = 4'd0;
                stop_d = 1'b0;
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = START;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_sync_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == TICK_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
                    if (bit_q == DATA_LAST) begin
                        bit_d   = 4'd0;
                        state_d = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PAR: begin
                if (cnt_q == TICK_LAST) begin
                    cnt_d   = '0;
                    perr_d  = parity_error(shift_q, rx_sync_q);
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == TICK_LAST) begin
                    cnt_d  = '0;
                    ferr_d = ferr_q | ~rx_sync_q;
                    if (stop_q == STOP_LAST) begin
                        load_s       = 1'b1;
                        frame_ferr_s = ferr_q | ~rx_sync_q;
                        stop_d       = 1'b0;
                        state_d      = IDLE;
                    end else begin
                        stop_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output holding register: a new frame always wins; overrun flags a lost unaccepted one.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            overrun_err_q <= 1'b0;
            if (load_s) begin
                data_out_q    <= shift_q;
                parity_err_q  <= perr_q;
                framing_err_q <= frame_ferr_s;
                data_valid_q  <= 1'b1;
                overrun_err_q <= data_valid_q & ~data_ready;
            end else if (data_valid_q && data_ready) begin
                data_valid_q <= 1'b0;
            end
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign parity_err  = parity_err_q;
    assign framing_err = framing_err_q;
    assign overrun_err = overrun_err_q;
    assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_framed.sv
// Bench for uart_rx_framed: four configurations (8N1, 8E1, 8N2, 9O1) checked every cycle
// against a frame-level model, plus literal expectations for each directed scenario.
module tb_uart_rx_framed;
    localparam int BT = 16;
    localparam int HB = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] rx    = 4'hF;
    logic [3:0] rdy   = 4'hF;
    wire  [7:0] d0, d1, d2;
    wire  [8:0] d3;
    wire  [3:0] dv, pe, fe, oe, bsy;

    typedef struct {
        int         inst;
        int         at;
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } frame_t;

    frame_t     sched[$];
    int         nbits[4] = '{8, 8, 8, 9};
    int         par[4]   = '{0, 2, 0, 1};
    int         nstop[4] = '{1, 1, 2, 1};
    int         cyc = 0;
    int         compared = 0;
    int         mismatched = 0;
    logic       m_valid[4], m_pe[4], m_fe[4], m_oe[4];
    logic [8:0] m_data[4];
    int         dv_cnt[4] = '{0, 0, 0, 0};
    int         oe_cnt[4] = '{0, 0, 0, 0};
    logic [8:0] cap_d[4];
    logic       cap_pe[4], cap_fe[4];
    logic       rst_prev = 1'b1;
    logic [3:0] rdy_prev = 4'hF;

    uart_rx_framed #(.CLK_SPEED(160_000), .BAUD_RATE(10_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clock(clock), .reset(reset), .rx(rx[0]), .data_out(d0), .data_valid(dv[0]), .data_ready(rdy[0]),
        .parity_err(pe[0]), .framing_err(fe[0]), .overrun_err(oe[0]), .busy(bsy[0]));
    uart_rx_framed #(.CLK_SPEED(160_000), .BAUD_RATE(10_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clock(clock), .reset(reset), .rx(rx[1]), .data_out(d1), .data_valid(dv[1]), .data_ready(rdy[1]),
        .parity_err(pe[1]), .framing_err(fe[1]), .overrun_err(oe[1]), .busy(bsy[1]));
    uart_rx_framed #(.CLK_SPEED(160_000), .BAUD_RATE(10_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
        .clock(clock), .reset(reset), .rx(rx[2]), .data_out(d2), .data_valid(dv[2]), .data_ready(rdy[2]),
        .parity_err(pe[2]), .framing_err(fe[2]), .overrun_err(oe[2]), .busy(bsy[2]));
    uart_rx_framed #(.CLK_SPEED(160_000), .BAUD_RATE(10_000), .DATA_BITS(9), .PARITY(1), .STOP_BITS(1)) u_9o1 (
        .clock(clock), .reset(reset), .rx(rx[3]), .data_out(d3), .data_valid(dv[3]), .data_ready(rdy[3]),
        .parity_err(pe[3]), .framing_err(fe[3]), .overrun_err(oe[3]), .busy(bsy[3]));

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sends one frame starting just after a clock edge. The frame lands in the output
    // register when its last sample is taken: 2 synchroniser edges + 1 edge to see the
    // falling edge + half a bit + one full bit per sampled bit after the start bit.
    task automatic send(input int i, input logic [8:0] d, input logic pbit,
                        input logic [1:0] stops, input bit sched_it);
        int     k;
        int     n;
        frame_t f;
        @(posedge clock);
        #1;
        k = cyc;
        n = nbits[i] + ((par[i] != 0) ? 1 : 0) + nstop[i];
        if (sched_it) begin
            f.inst = i;
            f.at   = k + 3 + HB + BT * n;
            f.d    = (nbits[i] == 9) ? d : {1'b0, d[7:0]};
            if (par[i] == 1)      f.pe = ~(^f.d ^ pbit);
            else if (par[i] == 2) f.pe = ^f.d ^ pbit;
            else                  f.pe = 1'b0;
            f.fe = !stops[0] || (nstop[i] == 2 && !stops[1]);
            sched.push_back(f);
        end
        rx[i] = 1'b0;
        repeat (BT) @(posedge clock);
        #1;
        for (int b = 0; b < nbits[i]; b++) begin
            rx[i] = d[b];
            repeat (BT) @(posedge clock);
            #1;
        end
        if (par[i] != 0) begin
            rx[i] = pbit;
            repeat (BT) @(posedge clock);
            #1;
        end
        for (int s = 0; s < nstop[i]; s++) begin
            rx[i] = stops[s];
            repeat (BT) @(posedge clock);
            #1;
        end
    endtask

    task automatic idle(input int i, input int bits);
        rx[i] = 1'b1;
        repeat (bits * BT) @(posedge clock);
        #1;
    endtask

    // Model + compare: apply the edge that just happened, then check every output.
    initial begin
        int         idx;
        logic [8:0] ad;
        forever begin
            @(negedge clock);
            for (int i = 0; i < 4; i++) begin
                if (rst_prev) begin
                    m_valid[i] = 1'b0;
                    m_data[i]  = 9'h000;
                    m_pe[i]    = 1'b0;
                    m_fe[i]    = 1'b0;
                    m_oe[i]    = 1'b0;
                end else begin
                    idx = -1;
                    for (int j = 0; j < sched.size(); j++)
                        if (sched[j].inst == i && sched[j].at == cyc) idx = j;
                    if (idx >= 0) begin
                        m_oe[i]    = m_valid[i] & ~rdy_prev[i];
                        m_valid[i] = 1'b1;
                        m_data[i]  = sched[idx].d;
                        m_pe[i]    = sched[idx].pe;
                        m_fe[i]    = sched[idx].fe;
                        sched.delete(idx);
                    end else begin
                        m_oe[i] = 1'b0;
                        if (m_valid[i] && rdy_prev[i]) m_valid[i] = 1'b0;
                    end
                end
                case (i)
                    0:       ad = {1'b0, d0};
                    1:       ad = {1'b0, d1};
                    2:       ad = {1'b0, d2};
                    default: ad = d3;
                endcase
                check($sformatf("data_valid%0d", i), int'(dv[i]), int'(m_valid[i]));
                check($sformatf("data_out%0d", i), int'(ad), int'(m_data[i]));
                check($sformatf("parity_err%0d", i), int'(pe[i]), int'(m_pe[i]));
                check($sformatf("framing_err%0d", i), int'(fe[i]), int'(m_fe[i]));
                check($sformatf("overrun_err%0d", i), int'(oe[i]), int'(m_oe[i]));
                if (dv[i] === 1'b1) begin
                    dv_cnt[i]++;
                    cap_d[i]  = ad;
                    cap_pe[i] = pe[i];
                    cap_fe[i] = fe[i];
                end
                if (oe[i] === 1'b1) oe_cnt[i]++;
            end
            rst_prev = reset;
            rdy_prev = rdy;
        end
    end

    initial begin
        int  snap;
        bit  seen;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("busy_after_reset", int'(bsy), 0);
        check("valid_after_reset", int'(dv), 0);
        idle(0, 2);

        // 8N1 0xA5 with consumer ready: one-cycle valid, clean flags
        send(0, 9'h0A5, 1'b0, 2'b11, 1'b1);
        idle(0, 3);
        check("8n1_valid_cycles", dv_cnt[0], 1);
        check("8n1_data", int'(cap_d[0]), 'hA5);
        check("8n1_flags", int'({cap_pe[0], cap_fe[0]}), 0);

        // 8E1 0x07 with parity bit 0: three ones plus 0 is odd -> even-parity error
        send(1, 9'h007, 1'b0, 2'b11, 1'b1);
        idle(1, 3);
        check("8e1_data", int'(cap_d[1]), 'h07);
        check("8e1_parity_err", int'(cap_pe[1]), 1);
        check("8e1_framing_err", int'(cap_fe[1]), 0);

        // 8N2 0x3C with second stop low, then a long break that must not retrigger
        send(2, 9'h03C, 1'b0, 2'b01, 1'b1);
        rx[2] = 1'b0;
        repeat (40 * BT) @(posedge clock);
        #1;
        check("8n2_data", int'(cap_d[2]), 'h3C);
        check("8n2_framing_err", int'(cap_fe[2]), 1);
        check("8n2_break_busy", int'(bsy[2]), 0);
        idle(2, 3);
        check("8n2_frames", dv_cnt[2], 1);

        // Overrun: consumer stalled across two frames
        rdy[0] = 1'b0;
        send(0, 9'h011, 1'b0, 2'b11, 1'b1);
        idle(0, 2);
        send(0, 9'h022, 1'b0, 2'b11, 1'b1);
        idle(0, 2);
        check("overrun_pulses", oe_cnt[0], 1);
        check("overrun_data", int'(d0), 'h22);
        check("overrun_valid", int'(dv[0]), 1);
        rdy[0] = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("overrun_accepted", int'(dv[0]), 0);

        // Start glitch of 5 clocks: busy briefly, no frame
        snap = dv_cnt[0];
        rx[0] = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        rx[0] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (bsy[0] === 1'b1) seen = 1'b1;
        end
        check("glitch_busy_seen", int'(seen), 1);
        check("glitch_busy_end", int'(bsy[0]), 0);
        check("glitch_no_frame", dv_cnt[0], snap);

        // Reset mid-frame with the line still low: frame lost, no restart until a new edge
        rx[0] = 1'b0;
        repeat (60) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("midreset_outputs", int'({dv, oe, pe, fe}), 0);
        check("midreset_data", int'(d0), 0);
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (bsy[0] !== 1'b0) seen = 1'b1;
        end
        check("midreset_no_restart", int'(seen), 0);
        idle(0, 2);
        snap = dv_cnt[0];
        send(0, 9'h05A, 1'b0, 2'b11, 1'b1);
        idle(0, 3);
        check("after_reset_data", int'(cap_d[0]), 'h5A);
        check("after_reset_frames", dv_cnt[0] - snap, 1);

        // 9O1 0x1FF with parity bit 0: nine ones is odd -> no error, no truncation
        send(3, 9'h1FF, 1'b0, 2'b11, 1'b1);
        idle(3, 3);
        check("9o1_data", int'(cap_d[3]), 'h1FF);
        check("9o1_parity_err", int'(cap_pe[3]), 0);
        check("9o1_frames", dv_cnt[3], 1);
        check("pending_frames", sched.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/uart_rx_framed.md
UART_RX_FRAMED -- requirements
Module: uart_rx_framed

Interface
REQ-001 SHALL have parameter CLK_SPEED, default 5_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, line bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits checked per frame, legal values 1 or 2.
REQ-006 SHALL derive BAUD_TICK = CLK_SPEED/BAUD_RATE and HALF_BAUD_TICK = BAUD_TICK/2 as localparams; tick counter width SHALL be $clog2(BAUD_TICK).
REQ-007 SHALL have port clock, input, 1, sole clock; all state updates on posedge.
REQ-008 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-009 SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-010 SHALL have port data_out, output, DATA_BITS, received word, LSB = first bit received.
REQ-011 SHALL have port data_valid, output, 1, data_out, parity_err and framing_err hold a frame not yet accepted.
REQ-012 SHALL have port data_ready, input, 1, consumer accepts the frame when high with data_valid.
REQ-013 SHALL have port parity_err, output, 1, parity mismatch on the held frame; always 0 when PARITY=0.
REQ-014 SHALL have port framing_err, output, 1, at least one stop bit of the held frame sampled low.
REQ-015 SHALL have port overrun_err, output, 1, one-cycle pulse when an unaccepted frame is overwritten.
REQ-016 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-017 rx SHALL pass through a 2-flop synchronizer (rx_sync); decode SHALL use rx_sync only.
REQ-018 FSM states SHALL be IDLE, START, DATA, PAR, STOP.
REQ-019 IDLE->START SHALL occur only on a 1->0 transition of rx_sync; a line held low (break) SHALL NOT retrigger.
REQ-020 START: tick counter counts from 0; at count HALF_BAUD_TICK-1, rx_sync=0 -> DATA with counter cleared; rx_sync=1 -> IDLE as a glitch, no output change.
REQ-021 DATA: sample rx_sync at each count BAUD_TICK-1, shift in LSB first, clear counter; after DATA_BITS samples go to PAR if PARITY!=0, else STOP.
REQ-022 PAR: one sample at BAUD_TICK-1; error if XOR(data, parity bit) is not 1 for odd or not 0 for even.
REQ-023 STOP: STOP_BITS samples at BAUD_TICK-1; any low sample sets the frame's framing error; after the last sample go to IDLE.
REQ-024 On the last stop-bit sample cycle the output register SHALL load data_out, parity_err and framing_err; data_valid SHALL be 1 the following cycle.
REQ-025 A frame with errors SHALL still be delivered, with its error flags set.
REQ-026 data_valid SHALL stay high, with data_out and flags stable, until a cycle with data_valid=1 and data_ready=1; it SHALL then be 0 the next cycle unless a new load coincides.
REQ-027 Load while data_valid=1 and data_ready=0: new frame overwrites, data_valid stays 1, overrun_err pulses high for 1 cycle.
REQ-028 Load coinciding with acceptance: new frame loads, data_valid stays 1, no overrun.
REQ-029 DATA_BITS=9 SHALL be supported without truncation.

Reset
REQ-030 reset SHALL put the FSM in IDLE, clear counters and the shift register, force rx_sync flops to 1, and drive data_out=0, data_valid=0, parity_err=0, framing_err=0, overrun_err=0, busy=0 on the next edge.
REQ-031 reset asserted mid-frame SHALL abandon the frame with no data_valid; after release, a new start SHALL need a fresh 1->0 edge.

Verification (bench parameters CLK_SPEED=160_000, BAUD_RATE=10_000, so BAUD_TICK=16)
REQ-032 8N1, send 0xA5, data_ready=1 -> data_valid for 1 cycle, data_out=0xA5, all flags 0.
REQ-033 8E1, send 0x07 with parity bit 0 -> data_out=0x07, parity_err=1, framing_err=0.
REQ-034 8N2, send 0x3C with second stop bit low -> data_out=0x3C, framing_err=1; line then held low for 40 bit times -> no further frame.
REQ-035 data_ready=0, send 0x11 then 0x22 -> overrun_err pulses once at the second load; data_out=0x22, data_valid=1.
REQ-036 rx low pulse of 5 clocks -> busy rises, returns to IDLE, data_valid stays 0; reset asserted mid-frame -> outputs 0, next frame 0x5A received correctly.
REQ-037 9O1, send 0x1FF with parity bit 0 -> data_out=0x1FF, parity_err=0.
